// File: rtl/cpu_run_ctrl_if.sv
// Purpose: groups the load stream, dump stream and both CPU memory external ports.
// Latency: none, wires only.
// Backpressure: ld_valid/ld_ready and dump_valid/dump_ready are plain valid-ready pairs.
// master = run controller side, slave = host / cpu side.
interface cpu_run_ctrl_if;
    // load stream (host -> controller)
    logic        ld_valid;
    logic        ld_ready;
    logic [63:0] ld_data;
    // dump stream (controller -> host)
    logic        dump_valid;
    logic        dump_ready;
    logic [63:0] dump_data;
    // instruction-memory external port
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    // data-memory external port
    logic [63:0] addr_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [63:0] wdata_ext_2;
    logic [63:0] rdata_ext_2;

    modport master (
        input  ld_valid, ld_data, dump_ready, rdata_ext_2,
        output ld_ready, dump_valid, dump_data,
        output addr_ext, wen_ext, ren_ext, wdata_ext,
        output addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
    );

    modport slave (
        output ld_valid, ld_data, dump_ready, rdata_ext_2,
        input  ld_ready, dump_valid, dump_data,
        input  addr_ext, wen_ext, ren_ext, wdata_ext,
        input  addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Purpose: sequences one program run on the cpu: load imem, load dmem, run, dump dmem prefix.
// Latency: start -> busy next cycle; loads 1 word/cycle; dump >= 2 cycles/word; done 1 cycle after last phase.
// Backpressure: ld_ready only in load states; dump word held stable on dump_data until dump_ready.
// Ports: clk/arst_n; start/abort and latched lengths/run_cycles; bus (cpu_run_ctrl_if.master)
//        carries load/dump streams and both memory ext ports; cpu_enable, busy, done, state out.
module cpu_run_ctrl #(
    parameter int IMEM_WORDS = 128,
    parameter int DMEM_WORDS = 128,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       imem_len,
    input  logic [7:0]       dmem_len,
    input  logic [7:0]       dump_len,
    input  logic [CNT_W-1:0] run_cycles,
    cpu_run_ctrl_if.master   bus,
    output logic             cpu_enable,
    output logic             busy,
    output logic             done,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_I   = 3'd1,
        S_LOAD_D   = 3'd2,
        S_RUN      = 3'd3,
        S_DUMP_RD  = 3'd4,
        S_DUMP_OUT = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    localparam logic [8:0] IMEM_MAX = 9'(IMEM_WORDS);
    localparam logic [8:0] DMEM_MAX = 9'(DMEM_WORDS);

    state_t           state_q, state_d;
    logic [7:0]       idx_q, idx_d;
    logic [7:0]       imem_len_q, imem_len_d;
    logic [7:0]       dmem_len_q, dmem_len_d;
    logic [7:0]       dump_len_q, dump_len_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [63:0]      hold_q, hold_d;
    // set once the holding register has captured the word for the current DUMP_OUT
    logic             cap_q, cap_d;

    logic [7:0] imem_len_c, dmem_len_c, dump_len_c;

    // First phase with work left, in fixed phase order.
    function automatic state_t first_phase(input logic i_nz, input logic d_nz,
                                           input logic r_nz, input logic u_nz);
        if (i_nz) return S_LOAD_I;
        if (d_nz) return S_LOAD_D;
        if (r_nz) return S_RUN;
        if (u_nz) return S_DUMP_RD;
        return S_DONE;
    endfunction

    // Requested lengths clamped to the memory depths.
    always_comb begin
        imem_len_c = ({1'b0, imem_len} > IMEM_MAX) ? IMEM_MAX[7:0] : imem_len;
        dmem_len_c = ({1'b0, dmem_len} > DMEM_MAX) ? DMEM_MAX[7:0] : dmem_len;
        dump_len_c = ({1'b0, dump_len} > DMEM_MAX) ? DMEM_MAX[7:0] : dump_len;
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        imem_len_d = imem_len_q;
        dmem_len_d = dmem_len_q;
        dump_len_d = dump_len_q;
        run_cnt_d  = run_cnt_q;
        hold_d     = hold_q;
        cap_d      = cap_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    imem_len_d = imem_len_c;
                    dmem_len_d = dmem_len_c;
                    dump_len_d = dump_len_c;
                    run_cnt_d  = run_cycles;
                    idx_d      = 8'd0;
                    state_d    = first_phase(imem_len_c != 8'd0, dmem_len_c != 8'd0,
                                             run_cycles != '0, dump_len_c != 8'd0);
                end
            end
            S_LOAD_I: begin
                if (bus.ld_valid) begin
                    if (idx_q == imem_len_q - 8'd1) begin
                        idx_d   = 8'd0;
                        state_d = first_phase(1'b0, dmem_len_q != 8'd0,
                                              run_cnt_q != '0, dump_len_q != 8'd0);
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            S_LOAD_D: begin
                if (bus.ld_valid) begin
                    if (idx_q == dmem_len_q - 8'd1) begin
                        idx_d   = 8'd0;
                        state_d = first_phase(1'b0, 1'b0, run_cnt_q != '0, dump_len_q != 8'd0);
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            S_RUN: begin
                // counter holds the cycles still to run including this one
                run_cnt_d = run_cnt_q - CNT_W'(1);
                if (run_cnt_q == CNT_W'(1)) begin
                    state_d = first_phase(1'b0, 1'b0, 1'b0, dump_len_q != 8'd0);
                end
            end
            S_DUMP_RD: begin
                cap_d   = 1'b0;
                state_d = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                // read data is on rdata_ext_2 during the first DUMP_OUT cycle
                if (!cap_q) begin
                    hold_d = bus.rdata_ext_2;
                    cap_d  = 1'b1;
                end
                if (bus.dump_ready) begin
                    if (idx_q == dump_len_q - 8'd1) begin
                        idx_d   = 8'd0;
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = S_DUMP_RD;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // abort wins over every transition above
        if (abort) begin
            state_d    = S_IDLE;
            idx_d      = 8'd0;
            imem_len_d = 8'd0;
            dmem_len_d = 8'd0;
            dump_len_d = 8'd0;
            run_cnt_d  = '0;
            cap_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= 8'd0;
            imem_len_q <= 8'd0;
            dmem_len_q <= 8'd0;
            dump_len_q <= 8'd0;
            run_cnt_q  <= '0;
            hold_q     <= 64'd0;
            cap_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            imem_len_q <= imem_len_d;
            dmem_len_q <= dmem_len_d;
            dump_len_q <= dump_len_d;
            run_cnt_q  <= run_cnt_d;
            hold_q     <= hold_d;
            cap_q      <= cap_d;
        end
    end

    // Outputs decode the registered state; write enables follow ld_valid in load states only.
    always_comb begin
        bus.ld_ready    = (state_q == S_LOAD_I) || (state_q == S_LOAD_D);
        bus.wen_ext     = (state_q == S_LOAD_I) && bus.ld_valid;
        bus.ren_ext     = 1'b0;
        bus.addr_ext    = (state_q == S_LOAD_I) ? {54'd0, idx_q, 2'b00} : 64'd0;
        bus.wdata_ext   = (state_q == S_LOAD_I) ? bus.ld_data[31:0] : 32'd0;
        bus.wen_ext_2   = (state_q == S_LOAD_D) && bus.ld_valid;
        bus.ren_ext_2   = (state_q == S_DUMP_RD);
        bus.addr_ext_2  = ((state_q == S_LOAD_D) || (state_q == S_DUMP_RD))
                          ? {53'd0, idx_q, 3'b000} : 64'd0;
        bus.wdata_ext_2 = (state_q == S_LOAD_D) ? bus.ld_data : 64'd0;
        bus.dump_valid  = (state_q == S_DUMP_OUT);
        // pass read data through until it is captured, then serve the holding register
        bus.dump_data   = (state_q != S_DUMP_OUT) ? 64'd0
                          : (cap_q ? hold_q : bus.rdata_ext_2);
        cpu_enable      = (state_q == S_RUN);
        busy            = (state_q != S_IDLE);
        done            = (state_q == S_DONE);
        state           = state_q;
    end

endmodule
